mem_ntv_bridge: RTL and testbench
=================================

// Module: mem_ntv_bridge
// PURPOSE
//  Parametrised successor of the core/SoC native memory port. The core keeps its single-cycle native request
//  (addr/wdata/w_en/r_en/byteenable), but gains a stall for back-pressure. Requests are queued in an in-order
//  request FIFO and issued on a valid/ready memory channel. Read responses return in order and are counted
//  against an outstanding-read limit. Sits between the core LSU/fetch port and the SoC interconnect.
// PARAMETERS
//  ADDR_W           32  address width (bits)
//  DATA_W           32  data width; power of 2, >=32, multiple of 8
//  REQ_DEPTH        4   request FIFO entries; power of 2, >=2
//  MAX_OUTSTANDING  4   max reads issued without response, 1..15
// PORTS
//  clk              in   1         clock, all logic rising-edge
//  rst_n            in   1         asynchronous active-low reset
//  core_addr        in   ADDR_W    request address (byte address)
//  core_wdata       in   DATA_W    write data
//  core_w_en        in   1         write request
//  core_r_en        in   1         read request
//  core_byteenable  in   DATA_W/8  byte lanes
//  core_stall       out  1         1 = request this cycle not accepted, hold it
//  core_rdata       out  DATA_W    read data
//  core_rvalid      out  1         core_rdata valid, one-cycle pulse
//  core_misalign    out  1         misaligned request dropped (see CONFIGURATION)
//  mem_req_valid    out  1         request valid
//  mem_req_ready    in   1         memory accepts request
//  mem_req_we       out  1         1 = write, 0 = read
//  mem_req_addr     out  ADDR_W    request address
//  mem_req_wdata    out  DATA_W    write data
//  mem_req_be       out  DATA_W/8  byte enables
//  mem_rsp_valid    in   1         read response valid, in order; no back-pressure
//  mem_rsp_rdata    in   DATA_W    read response data
//  err_unexp_rsp    out  1         sticky: mem_rsp_valid seen with zero reads outstanding
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; outstanding count 0; err_unexp_rsp 0.
//  Accept:
//   - Request accepted when (core_w_en|core_r_en) & !core_stall.
//   - w_en&r_en together = write; the read is ignored.
//   - core_stall = (fifo_count==REQ_DEPTH), from registered count. A pop in the same cycle does NOT clear stall.
//  Enqueue/issue:
//   - An accepted request is pushed at the clock edge.
//   - mem_req_* is driven from the FIFO head; mem_req_valid = !empty & issue_ok.
//   - Min latency: core request in cycle N -> mem_req_valid in N+1.
//   - Pop on mem_req_valid & mem_req_ready. Head fields stay stable while valid & !ready.
//  Read limit:
//   - issue_ok = head is a write | outst<MAX_OUTSTANDING | mem_rsp_valid.
//   - A response arriving in the same cycle frees a slot, so reads can issue at the limit.
//   - outst += read pop; outst -= mem_rsp_valid. Simultaneous +1/-1 leaves the count unchanged.
//  Response:
//   - core_rdata <= mem_rsp_rdata; core_rvalid <= mem_rsp_valid & (outst!=0). Both are registered, so +1 cycle.
//   - core_rdata holds its value when core_rvalid=0.
//  Unexpected response: mem_rsp_valid with outst==0 -> dropped, no rvalid, outst stays 0, err_unexp_rsp set until reset.
//  Wrap-around: FIFO pointers are log2(REQ_DEPTH)+1 bits; full/empty from the MSB compare.
//  Reset mid-operation: FIFO and outstanding count are cleared. In-flight responses are lost and the memory side must be reset together.
//  Ordering: strictly in order; no read-after-write bypass or forwarding.
// CONFIGURATION
//  MEM_NTV_ALIGN_CHECK_EN defined:
//   - An accepted request with core_addr[log2(DATA_W/8)-1:0]!=0 is not pushed and issues no memory transaction.
//   - core_misalign pulses 1 in the cycle after acceptance.
//   - A misaligned read never produces core_rvalid.
//  Undefined: low address bits pass through unchanged; core_misalign tied 0. The port exists in both builds.
// STRUCTURE
//  mem_ntv_pkg:
//   - mem_ntv_req_t packed struct {we, addr, wdata, be}, parametrised via localparams.
//   - Function clog2-safe ptr width and MEM_NTV_BE_W = DATA_W/8.
//  Sub-module mem_ntv_fifo:
//   - Generic synchronous FIFO: WIDTH, DEPTH, push/pop/full/empty/count.
//   - Holds mem_ntv_req_t entries.
//  Top holds the accept/stall logic, outstanding counter, response register and error flag.
// TESTING
//  1 Reset then idle: all outputs 0; core_stall=0; mem_req_valid=0.
//  2 Write A=0x100, D=0xDEADBEEF, be=0xF, ready=1:
//    - mem_req_valid=1 one cycle later, we=1, same fields.
//    - No core_rvalid.
//  3 Read 0x200, mem_rsp_valid 2 cycles after issue with 0x12345678:
//    - core_rvalid=1 with core_rdata=0x12345678 the cycle after rsp.
//    - outst returns to 0.
//  4 ready=0, push 4 writes:
//    - core_stall=1 after the 4th; the 5th is held.
//    - ready=1: 5th accepted; ordering is preserved at mem_req.
//  5 MAX_OUTSTANDING=2, 3 back-to-back reads, no rsp:
//    - 3rd stays at head with mem_req_valid=0.
//    - A rsp cycle issues it in the same cycle.
//  6 mem_rsp_valid with outst=0 -> err_unexp_rsp=1 sticky, no core_rvalid.
//    With ALIGN_CHECK_EN: read 0x202 -> core_misalign pulse, no mem_req.

Source files
------------

// File: rtl/mem_ntv_pkg.sv
// -----------------------------------------------------------------------------
// mem_ntv_pkg
// Shared types, default widths and small sizing helpers for the native memory
// bridge (mem_ntv_bridge) and its request FIFO (mem_ntv_fifo).
//
// Contents:
//   MEM_NTV_ADDR_W / MEM_NTV_DATA_W / MEM_NTV_BE_W : default widths
//   mem_ntv_req_t    : one queued request {we, addr, wdata, be} at default widths
//   mem_ntv_ptr_w()  : FIFO pointer width, one extra wrap bit above the index
//   mem_ntv_be_w()   : number of byte lanes for a given data width
//
// Configuration macro used by the bridge: MEM_NTV_ALIGN_CHECK_EN
// -----------------------------------------------------------------------------
package mem_ntv_pkg;

  localparam int MEM_NTV_ADDR_W = 32;
  localparam int MEM_NTV_DATA_W = 32;
  localparam int MEM_NTV_BE_W   = MEM_NTV_DATA_W / 8;

  // A request as it sits in the FIFO; we=1 means write, we=0 means read.
  typedef struct packed {
    logic                      we;
    logic [MEM_NTV_ADDR_W-1:0] addr;
    logic [MEM_NTV_DATA_W-1:0] wdata;
    logic [MEM_NTV_BE_W-1:0]   be;
  } mem_ntv_req_t;

  // Index bits plus one wrap bit, so full and empty can be told apart by
  // comparing the top bit of the read and write pointers.
  function automatic int mem_ntv_ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth) + 1;
  endfunction

  function automatic int mem_ntv_be_w(input int dataW);
    return dataW / 8;
  endfunction

endpackage

// File: rtl/mem_ntv_fifo.sv
// -----------------------------------------------------------------------------
// mem_ntv_fifo
// Generic synchronous FIFO used to queue native memory requests in order.
// DEPTH must be a power of two (>= 2). Pointers carry one extra wrap bit.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears pointers)
//   i_push   in   write i_wdata at the tail (ignored when full)
//   i_wdata  in   entry to push
//   i_pop    in   drop the head entry (ignored when empty)
//   o_rdata  out  head entry
//   o_full   out  all DEPTH entries occupied
//   o_empty  out  no entries
//   o_count  out  number of occupied entries
// -----------------------------------------------------------------------------
module mem_ntv_fifo
  import mem_ntv_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = mem_ntv_ptr_w(DEPTH),
  localparam int IDX_W = PTR_W - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  // Same index with different wrap bits means the writer has lapped the reader.
  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_full  = (r_wrPtr[IDX_W] != r_rdPtr[IDX_W]) &&
                   (r_wrPtr[IDX_W-1:0] == r_rdPtr[IDX_W-1:0]);
  assign o_count = r_wrPtr - r_rdPtr;
  assign o_rdata = r_mem[r_rdPtr[IDX_W-1:0]];

  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop  & ~o_empty;

  // Storage has no reset; an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr[IDX_W-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/mem_ntv_bridge.sv
// -----------------------------------------------------------------------------
// mem_ntv_bridge
// Bridges the core's single-cycle native memory request (with stall) onto a
// valid/ready memory request channel. Requests queue in an in-order FIFO;
// read responses return in order and are limited by an outstanding-read count.
//
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   core_addr/wdata/w_en/r_en/byteenable   native request from the core
//   core_stall      out  request this cycle not accepted (FIFO full)
//   core_rdata      out  registered read data, held between responses
//   core_rvalid     out  one-cycle pulse, core_rdata valid
//   core_misalign   out  pulse: misaligned request dropped (align build only)
//   mem_req_valid/ready/we/addr/wdata/be   request channel, driven from head
//   mem_rsp_valid/rdata        in-order read responses, no back-pressure
//   err_unexp_rsp   out  sticky: response seen with no read outstanding
//
// Configuration macro: MEM_NTV_ALIGN_CHECK_EN
//   defined   : requests with nonzero byte-offset bits are dropped and flagged
//   undefined : address passes through unchanged, core_misalign tied 0
// -----------------------------------------------------------------------------
module mem_ntv_bridge
  import mem_ntv_pkg::*;
#(
  parameter int ADDR_W          = MEM_NTV_ADDR_W,
  parameter int DATA_W          = MEM_NTV_DATA_W,
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic                core_w_en,
  input  logic                core_r_en,
  input  logic [DATA_W/8-1:0] core_byteenable,
  output logic                core_stall,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_rvalid,
  output logic                core_misalign,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_be,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  output logic                err_unexp_rsp
);

  localparam int BE_W  = mem_ntv_be_w(DATA_W);
  localparam int PTR_W = mem_ntv_ptr_w(REQ_DEPTH);
  localparam int OFF_W = $clog2(BE_W);
  localparam logic [3:0] OUTST_MAX = 4'(MAX_OUTSTANDING);

  // Same layout as mem_ntv_req_t, sized for this instance's widths.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  req_t             w_pushReq;
  req_t             w_head;
  logic [REQ_W-1:0] w_headBits;
  logic             w_full;
  logic             w_empty;
  logic [PTR_W-1:0] w_count;
  logic             w_accept;
  logic             w_misalign;
  logic             w_push;
  logic             w_pop;
  logic             w_issueOk;
  logic             w_readPop;
  logic             w_rspOk;

  logic [3:0]        r_outst;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_err;

  // Stall comes only from the registered occupancy, so a pop in the same
  // cycle cannot release it; this keeps core_stall free of mem_req_ready.
  assign core_stall = (w_count == PTR_W'(REQ_DEPTH));
  assign w_accept   = (core_w_en | core_r_en) & ~core_stall;

`ifdef MEM_NTV_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_misalign = |core_addr[OFF_W-1:0];

  // One-cycle pulse reporting that the request just accepted was dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= w_accept & w_misalign;
  end

  assign core_misalign = r_misalign;
`else
  assign w_misalign    = 1'b0;
  assign core_misalign = 1'b0;
`endif

  // A simultaneous write and read is treated as a write.
  assign w_pushReq.we    = core_w_en;
  assign w_pushReq.addr  = core_addr;
  assign w_pushReq.wdata = core_wdata;
  assign w_pushReq.be    = core_byteenable;

  assign w_push = w_accept & ~w_misalign & ~w_full;

  mem_ntv_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (REQ_DEPTH)
  ) u_reqFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_pushReq),
    .i_pop   (w_pop),
    .o_rdata (w_headBits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head = req_t'(w_headBits);

  // A response in the same cycle frees a slot, so a read may issue at the limit.
  assign w_issueOk     = w_head.we | (r_outst < OUTST_MAX) | mem_rsp_valid;
  assign mem_req_valid = ~w_empty & w_issueOk;

  // Fields are forced to zero when empty so the channel never shows stale data.
  assign mem_req_we    = ~w_empty & w_head.we;
  assign mem_req_addr  = w_empty ? '0 : w_head.addr;
  assign mem_req_wdata = w_empty ? '0 : w_head.wdata;
  assign mem_req_be    = w_empty ? '0 : w_head.be;

  assign w_pop     = mem_req_valid & mem_req_ready;
  assign w_readPop = w_pop & ~w_head.we;
  assign w_rspOk   = mem_rsp_valid & (r_outst != 4'd0);

  // Outstanding count, response register and the sticky error flag.
  // Responses arriving with nothing outstanding are dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outst  <= 4'd0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_outst  <= r_outst + {3'd0, w_readPop} - {3'd0, w_rspOk};
      r_rvalid <= w_rspOk;
      if (w_rspOk) r_rdata <= mem_rsp_rdata;
      if (mem_rsp_valid && (r_outst == 4'd0)) r_err <= 1'b1;
    end
  end

  assign core_rdata    = r_rdata;
  assign core_rvalid   = r_rvalid;
  assign err_unexp_rsp = r_err;

endmodule

// File: tb/tb_mem_ntv_bridge.sv
// -----------------------------------------------------------------------------
// tb_mem_ntv_bridge
// Self-checking bench for mem_ntv_bridge (REQ_DEPTH=4, MAX_OUTSTANDING=2).
// A queue-based reference model tracks pending requests, outstanding reads and
// expected registered outputs; every cycle the DUT is compared against it.
// Honours MEM_NTV_ALIGN_CHECK_EN when the bundle is built with it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_ntv_bridge;

  localparam int REQ_DEPTH = 4;
  localparam int MAX_OUT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_w_en;
  logic        core_r_en;
  logic [3:0]  core_byteenable;
  logic        core_stall;
  logic [31:0] core_rdata;
  logic        core_rvalid;
  logic        core_misalign;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        err_unexp_rsp;

  always #5 clk = ~clk;

  mem_ntv_bridge #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .REQ_DEPTH       (REQ_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .core_addr       (core_addr),
    .core_wdata      (core_wdata),
    .core_w_en       (core_w_en),
    .core_r_en       (core_r_en),
    .core_byteenable (core_byteenable),
    .core_stall      (core_stall),
    .core_rdata      (core_rdata),
    .core_rvalid     (core_rvalid),
    .core_misalign   (core_misalign),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_we      (mem_req_we),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_req_be      (mem_req_be),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_rdata   (mem_rsp_rdata),
    .err_unexp_rsp   (err_unexp_rsp)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } tbReq_t;

  // Reference model state
  tbReq_t      modelQ[$];
  int          modelOutst   = 0;
  bit          modelErr     = 1'b0;
  bit          expRvalid    = 1'b0;
  logic [31:0] expRdata     = 32'h0;
  bit          expMisalign  = 1'b0;
  bit          lastAccepted = 1'b0;

  int tests = 0;
  int fails = 0;

  // One comparison: count it, and report it when it does not hold.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit isMisaligned(input logic [31:0] a);
`ifdef MEM_NTV_ALIGN_CHECK_EN
    return (a[1:0] != 2'b00);
`else
    return (a[1:0] != 2'b00) && 1'b0;
`endif
  endfunction

  // Drive one cycle of inputs, compare every output with the model, then
  // advance the model across the following rising edge.
  task automatic applyStimulus(input bit wEn, input bit rEn, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input bit ready, input bit rspValid,
                               input logic [31:0] rspData);
    bit expStall, expValid, accepted, popped, inc, dec;
    @(negedge clk);
    core_w_en       = wEn;
    core_r_en       = rEn;
    core_addr       = addr;
    core_wdata      = wdata;
    core_byteenable = be;
    mem_req_ready   = ready;
    mem_rsp_valid   = rspValid;
    mem_rsp_rdata   = rspData;
    #1;
    expStall = (modelQ.size() == REQ_DEPTH);
    expValid = (modelQ.size() > 0) &&
               (modelQ[0].we || (modelOutst < MAX_OUT) || rspValid);
    checkOutput("core_stall", core_stall, expStall);
    checkOutput("mem_req_valid", mem_req_valid, expValid);
    if (expValid) begin
      checkOutput("mem_req_we", mem_req_we, modelQ[0].we);
      checkOutput("mem_req_addr", mem_req_addr, modelQ[0].addr);
      checkOutput("mem_req_be", mem_req_be, modelQ[0].be);
      if (modelQ[0].we) checkOutput("mem_req_wdata", mem_req_wdata, modelQ[0].wdata);
    end
    checkOutput("core_rvalid", core_rvalid, expRvalid);
    checkOutput("core_rdata", core_rdata, expRdata);
    checkOutput("err_unexp_rsp", err_unexp_rsp, modelErr);
    checkOutput("core_misalign", core_misalign, expMisalign);

    accepted = (wEn || rEn) && !expStall;
    popped   = expValid && ready;
    inc      = popped && !modelQ[0].we;
    if (popped) void'(modelQ.pop_front());
    dec = rspValid && (modelOutst != 0);
    if (rspValid && modelOutst == 0) modelErr = 1'b1;
    modelOutst = modelOutst + int'(inc) - int'(dec);
    expRvalid  = dec;
    if (dec) expRdata = rspData;
    expMisalign = accepted && isMisaligned(addr);
    if (accepted && !isMisaligned(addr)) modelQ.push_back('{wEn, addr, wdata, be});
    lastAccepted = accepted;
  endtask

  task automatic idleCycles(input int n, input bit ready);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, ready, 0, 32'h0);
  endtask

  initial begin
    logic [31:0] wrData [5];
    bit          rspV;
    logic [31:0] rndAddr;

    rst_n           = 1'b0;
    core_addr       = '0;
    core_wdata      = '0;
    core_w_en       = 1'b0;
    core_r_en       = 1'b0;
    core_byteenable = '0;
    mem_req_ready   = 1'b0;
    mem_rsp_valid   = 1'b0;
    mem_rsp_rdata   = '0;

    // Test 1: reset values, then idle
    repeat (3) @(negedge clk);
    checkOutput("rst_stall", core_stall, 0);
    checkOutput("rst_rdata", core_rdata, 0);
    checkOutput("rst_rvalid", core_rvalid, 0);
    checkOutput("rst_misalign", core_misalign, 0);
    checkOutput("rst_req_valid", mem_req_valid, 0);
    checkOutput("rst_req_we", mem_req_we, 0);
    checkOutput("rst_req_addr", mem_req_addr, 0);
    checkOutput("rst_req_wdata", mem_req_wdata, 0);
    checkOutput("rst_req_be", mem_req_be, 0);
    checkOutput("rst_err", err_unexp_rsp, 0);
    rst_n = 1'b1;
    idleCycles(2, 1);

    // Test 2: single write appears on the channel one cycle later
    applyStimulus(1, 0, 32'h100, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
    checkOutput("t2_valid", mem_req_valid, 1);
    checkOutput("t2_we", mem_req_we, 1);
    checkOutput("t2_addr", mem_req_addr, 32'h100);
    checkOutput("t2_wdata", mem_req_wdata, 32'hDEADBEEF);
    checkOutput("t2_be", mem_req_be, 4'hF);
    idleCycles(2, 1);
    checkOutput("t2_no_rvalid", core_rvalid, 0);

    // Test 3: read, response two cycles after issue
    applyStimulus(0, 1, 32'h200, 32'h0, 4'hF, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
    checkOutput("t3_issue_addr", mem_req_addr, 32'h200);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h12345678);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
    checkOutput("t3_rvalid", core_rvalid, 1);
    checkOutput("t3_rdata", core_rdata, 32'h12345678);
    idleCycles(1, 1);
    checkOutput("t3_rdata_hold", core_rdata, 32'h12345678);

    // Test 4: fill the FIFO with ready low, then release
    for (int i = 0; i < 5; i++) wrData[i] = $urandom;
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 32'h300 + 32'(4 * i), wrData[i], 4'(i + 1), 0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 32'h310, wrData[4], 4'h5, 0, 0, 32'h0);
      checkOutput("t4_stall_held", core_stall, 1);
    end
    applyStimulus(1, 0, 32'h310, wrData[4], 4'h5, 1, 0, 32'h0);
    checkOutput("t4_stall_pop_cycle", core_stall, 1);
    applyStimulus(1, 0, 32'h310, wrData[4], 4'h5, 1, 0, 32'h0);
    checkOutput("t4_stall_released", core_stall, 0);
    checkOutput("t4_fifth_head_order", mem_req_addr, 32'h304);
    idleCycles(6, 1);

    // Test 5: read limit of two, third read waits for a response
    applyStimulus(0, 1, 32'h400, 32'h0, 4'hF, 1, 0, 32'h0);
    applyStimulus(0, 1, 32'h404, 32'h0, 4'hF, 1, 0, 32'h0);
    applyStimulus(0, 1, 32'h408, 32'h0, 4'hF, 1, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
      checkOutput("t5_blocked", mem_req_valid, 0);
    end
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'hA0A0A0A0);
    checkOutput("t5_issue_on_rsp", mem_req_valid, 1);
    checkOutput("t5_issue_addr", mem_req_addr, 32'h408);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'hB1B1B1B1);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'hC2C2C2C2);
    idleCycles(2, 1);
    checkOutput("t5_last_rdata", core_rdata, 32'hC2C2C2C2);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      rndAddr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(7, 0) == 0) rndAddr[1:0] = 2'($urandom_range(3, 1));
      rspV = (modelOutst > 0) && ($urandom_range(1, 0) == 1);
      applyStimulus($urandom_range(2, 0) == 0, $urandom_range(2, 0) == 0, rndAddr,
                    $urandom, 4'($urandom), $urandom_range(3, 0) != 0, rspV, $urandom);
    end
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, modelOutst > 0, $urandom);
    idleCycles(2, 1);

    // Test 6: unexpected response sets a sticky error and no rvalid
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h55AA55AA);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
    checkOutput("t6_err_set", err_unexp_rsp, 1);
    checkOutput("t6_no_rvalid", core_rvalid, 0);
    idleCycles(3, 1);
    checkOutput("t6_err_sticky", err_unexp_rsp, 1);

`ifdef MEM_NTV_ALIGN_CHECK_EN
    applyStimulus(0, 1, 32'h202, 32'h0, 4'hF, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
    checkOutput("t6_misalign_pulse", core_misalign, 1);
    checkOutput("t6_misalign_no_req", mem_req_valid, 0);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
    checkOutput("t6_misalign_end", core_misalign, 0);
    checkOutput("t6_misalign_no_rvalid", core_rvalid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
